stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 199 +++++++++++++++++++
 tb/tb_stream_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// stream_packer: packs DATA_WIDTH-bit samples LSB-first into PACK_NUM-lane words.
// Each word carries frame start/end tags and is buffered in a word FIFO. The FIFO
// has a registered read port with one cycle of latency.
// Optional feature: define STREAM_PACKER_STATS_EN to count the words of each frame
// on frame_words_o. Without the macro, frame_words_o is tied to zero and the
// counter is not built.
module stream_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACK_NUM    = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int AFULL_LEVEL = 48
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           data_valid_i,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           sop_i,
    input  logic                           eop_i,
    input  logic                           sof_i,
    input  logic                           eof_i,
    input  logic                           rd_i,
    output logic [PACK_NUM*DATA_WIDTH-1:0] word_o,
    output logic                           word_valid_o,
    output logic                           word_sof_o,
    output logic                           word_eof_o,
    output logic                           empty_o,
    output logic                           afull_o,
    output logic                           overflow_o,
    output logic                           sync_err_o,
    output logic [15:0]                    frame_words_o
);

    localparam int WORD_W  = PACK_NUM * DATA_WIDTH;
    localparam int CNT_W   = $clog2(PACK_NUM);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = WORD_W + 2;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_NUM - 1);
    localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      AFULL_CNT = (AW+1)'(AFULL_LEVEL);

    // Line markers are accepted on the sample interface but carry no packing meaning.
    logic unused_markers;
    assign unused_markers = sop_i ^ eop_i;

    // ---------------- packer ----------------
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  lane;
    logic [WORD_W-1:0] part_q, part_d;
    logic              part_sof_q, part_sof_d;
    logic              word_done;
    logic              resync;

    logic              wr_pend_q;
    logic [WORD_W-1:0] wr_word_q;
    logic              wr_sof_q;
    logic              wr_eof_q;
    logic              sync_err_q;

    // Place the incoming sample into its lane; a sof always restarts at lane 0.
    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    always_comb begin
        resync     = data_valid_i && sof_i && (count_q != '0);
        lane       = sof_i ? '0 : count_q;
        part_d     = sof_i ? '0 : part_q;
        part_d[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = data_i;
        part_sof_d = (lane == '0) ? sof_i : part_sof_q;
        word_done  = (lane == LAST_LANE) || eof_i;
    end

    // Accumulate samples; a finished word is staged for the FIFO write on the next edge.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            part_q     <= '0;
            part_sof_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_word_q  <= '0;
            wr_sof_q   <= 1'b0;
            wr_eof_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            wr_pend_q <= 1'b0;
            if (resync) begin
                sync_err_q <= 1'b1;
            end
            if (data_valid_i) begin
                if (word_done) begin
                    wr_pend_q  <= 1'b1;
                    wr_word_q  <= part_d;
                    wr_sof_q   <= part_sof_d;
                    wr_eof_q   <= eof_i;
                    count_q    <= '0;
                    part_q     <= '0;
                    part_sof_q <= 1'b0;
                end else begin
                    count_q    <= lane + CNT_W'(1);
                    part_q     <= part_d;
                    part_sof_q <= part_sof_d;
                end
            end
        end
    end

    // ---------------- word FIFO ----------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        usedw_q, usedw_d;
    logic               fifo_full;
    logic               rd_en, wr_en;
    logic               empty_q, afull_q, overflow_q;
    logic [WORD_W-1:0]  word_q;
    logic               word_valid_q, word_sof_q, word_eof_q;

    // Reads need a non-empty flag; a write at full is allowed only alongside a read.
    always_comb begin
        fifo_full = (usedw_q == DEPTH_CNT);
        rd_en     = rd_i && !empty_q;
        wr_en     = wr_pend_q && (!fifo_full || rd_en);
        usedw_d   = usedw_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // Storage array write port.
    // NOTE: the storage array is not reset; emptiness comes from the reset pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {wr_sof_q, wr_eof_q, wr_word_q};
        end
    end

    // Pointers, occupancy, registered status flags and the held read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            usedw_q      <= '0;
            empty_q      <= 1'b1;
            afull_q      <= 1'b0;
            overflow_q   <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_sof_q   <= 1'b0;
            word_eof_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                {word_sof_q, word_eof_q, word_q} <= mem_q[rd_ptr_q];
            end
            if (wr_pend_q && fifo_full && !rd_en) begin
                overflow_q <= 1'b1;
            end
            word_valid_q <= rd_en;
            usedw_q      <= usedw_d;
            empty_q      <= (usedw_d == '0);
            afull_q      <= (usedw_d >= AFULL_CNT);
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign word_sof_o   = word_sof_q;
    assign word_eof_o   = word_eof_q;
    assign empty_o      = empty_q;
    assign afull_o      = afull_q;
    assign overflow_o   = overflow_q;
    assign sync_err_o   = sync_err_q;

    // ---------------- frame statistics ----------------
`ifdef STREAM_PACKER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] frame_words_q;

    // Words stored so far in the current frame, counting the sof word as the first.
    always_comb begin
        frame_cnt_d = wr_sof_q ? 16'd1 : frame_cnt_q + 16'd1;
    end

    // Advance on each stored word and publish the total when the eof word is stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            frame_words_q <= '0;
        end else if (wr_en) begin
            frame_cnt_q <= frame_cnt_d;
            if (wr_eof_q) begin
                frame_words_q <= frame_cnt_d;
            end
        end
    end

    assign frame_words_o = frame_words_q;
`else
    assign frame_words_o = '0;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (default parameters: 8-bit samples,
// 8 lanes, 64-word FIFO, almost-full at 48). Expected words come from a
// sample-list reference model of the packing rules.
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
    logic        rd_i = 1'b0;
    logic [63:0] word_o;
    logic        word_valid_o, word_sof_o, word_eof_o;
    logic        empty_o, afull_o, overflow_o, sync_err_o;
    logic [15:0] frame_words_o;

    int checks = 0;
    int errors = 0;

    stream_packer #(
        .DATA_WIDTH (8),
        .PACK_NUM   (8),
        .FIFO_DEPTH (64),
        .AFULL_LEVEL(48)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .sop_i        (sop_i),
        .eop_i        (eop_i),
        .sof_i        (sof_i),
        .eof_i        (eof_i),
        .rd_i         (rd_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_sof_o   (word_sof_o),
        .word_eof_o   (word_eof_o),
        .empty_o      (empty_o),
        .afull_o      (afull_o),
        .overflow_o   (overflow_o),
        .sync_err_o   (sync_err_o),
        .frame_words_o(frame_words_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [63:0] data;
    } exp_t;

    exp_t       exp_q[$];      // words the FIFO should hold, oldest first
    logic [7:0] cur[$];        // samples of the word being built
    logic       cur_sof;
    logic       exp_sync;
    logic       exp_ovf;
    int         frame_cnt;
    int         exp_frame;

    task automatic model_clear();
        exp_q.delete();
        cur.delete();
        cur_sof   = 1'b0;
        exp_sync  = 1'b0;
        exp_ovf   = 1'b0;
        frame_cnt = 0;
        exp_frame = 0;
    endtask

    task automatic model_emit(input logic eof);
        exp_t        e;
        logic [63:0] w;
        w = '0;
        foreach (cur[k]) w = w | ({56'b0, cur[k]} << (8 * k));
        e.sof  = cur_sof;
        e.eof  = eof;
        e.data = w;
        if (exp_q.size() < 64) begin
            exp_q.push_back(e);
            frame_cnt = cur_sof ? 1 : frame_cnt + 1;
            if (eof) exp_frame = frame_cnt;
        end else begin
            exp_ovf = 1'b1;
        end
        cur.delete();
        cur_sof = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof, input logic eof);
        if (sof && cur.size() != 0) begin
            exp_sync = 1'b1;
            cur.delete();
        end
        if (cur.size() == 0) cur_sof = sof;
        cur.push_back(d);
        if (cur.size() == 8 || eof) model_emit(eof);
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic send(input logic [7:0] d, input logic sof, input logic eof);
        @(negedge clk);
        data_valid_i = 1'b1;
        data_i       = d;
        sof_i        = sof;
        eof_i        = eof;
        sop_i        = 1'($urandom);
        eop_i        = 1'($urandom);
        rd_i         = 1'b0;
        model_accept(d, sof, eof);
    endtask

    // Idle cycles drive junk on the qualified inputs to show they are ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid_i = 1'b0;
            data_i       = 8'($urandom);
            sof_i        = 1'($urandom);
            eof_i        = 1'($urandom);
            sop_i        = 1'($urandom);
            eop_i        = 1'($urandom);
            rd_i         = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b1;
        data_valid_i = 1'b0;
        sof_i        = 1'b0;
        eof_i        = 1'b0;
        rd_i         = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic read_check(input string tag);
        exp_t e;
        logic exp_valid;
        @(negedge clk);
        data_valid_i = 1'b0;
        sof_i        = 1'b0;
        eof_i        = 1'b0;
        rd_i         = 1'b1;
        exp_valid    = (exp_q.size() != 0);
        e            = exp_valid ? exp_q.pop_front() : '0;
        @(negedge clk);
        rd_i = 1'b0;
        checks++;
        if (word_valid_o !== exp_valid) begin
            errors++;
            $display("FAIL %s word_valid_o: got %b expected %b", tag, word_valid_o, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if ({word_sof_o, word_eof_o, word_o} !== e) begin
                errors++;
                $display("FAIL %s word: got sof=%b eof=%b %h expected sof=%b eof=%b %h",
                         tag, word_sof_o, word_eof_o, word_o, e.sof, e.eof, e.data);
            end
        end
    endtask

    task automatic status_check(input string tag);
        logic [3:0]  exp_flags;
        logic [15:0] exp_fw;
        exp_flags = {exp_q.size() == 0, exp_q.size() >= 48, exp_ovf, exp_sync};
`ifdef STREAM_PACKER_STATS_EN
        exp_fw = 16'(exp_frame);
`else
        exp_fw = 16'd0;
`endif
        checks++;
        if ({empty_o, afull_o, overflow_o, sync_err_o} !== exp_flags) begin
            errors++;
            $display("FAIL %s flags{empty,afull,ovf,sync}: got %b expected %b",
                     tag, {empty_o, afull_o, overflow_o, sync_err_o}, exp_flags);
        end
        checks++;
        if (frame_words_o !== exp_fw) begin
            errors++;
            $display("FAIL %s frame_words_o: got %0d expected %0d", tag, frame_words_o, exp_fw);
        end
    endtask

    task automatic send_words(input int first, input int count);
        for (int w = first; w < first + count; w++) begin
            for (int k = 0; k < 8; k++) send((k == 0) ? 8'(w) : 8'($urandom), 1'b0, 1'b0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset(input string tag);
        apply_reset();
        checks++;
        if ({word_valid_o, word_sof_o, word_eof_o, empty_o, afull_o, overflow_o, sync_err_o} !== 7'b0001000) begin
            errors++;
            $display("FAIL %s reset flags: got %b expected %b", tag,
                     {word_valid_o, word_sof_o, word_eof_o, empty_o, afull_o, overflow_o, sync_err_o}, 7'b0001000);
        end
        checks++;
        if (word_o !== 64'h0) begin
            errors++;
            $display("FAIL %s reset word_o: got %h expected 0", tag, word_o);
        end
        checks++;
        if (frame_words_o !== 16'h0) begin
            errors++;
            $display("FAIL %s reset frame_words_o: got %0d expected 0", tag, frame_words_o);
        end
    endtask

    task automatic test_packing();
        apply_reset();
        for (int i = 1; i <= 16; i++) send(8'(i), i == 1, i == 16);
        idle(2);
        status_check("pack_status");
        read_check("pack_w0");
        read_check("pack_w1");
        idle(3);
        checks++;
        if ({word_valid_o, word_eof_o, word_o} !== {1'b0, 1'b1, 64'h100F0E0D0C0B0A09}) begin
            errors++;
            $display("FAIL pack_hold: got valid=%b eof=%b %h expected valid=0 eof=1 100f0e0d0c0b0a09",
                     word_valid_o, word_eof_o, word_o);
        end
        read_check("pack_empty_rd");
        checks++;
        if (word_o !== 64'h100F0E0D0C0B0A09) begin
            errors++;
            $display("FAIL pack_hold_after_empty_rd: got %h expected 100f0e0d0c0b0a09", word_o);
        end
    endtask

    task automatic test_eof_pad();
        apply_reset();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b1);
        idle(2);
        read_check("pad_word");
        checks++;
        if ({word_eof_o, word_o} !== {1'b1, 64'h0000000000CCBBAA}) begin
            errors++;
            $display("FAIL pad_literal: got eof=%b %h expected eof=1 0000000000ccbbaa", word_eof_o, word_o);
        end
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, 1'b0);
        idle(2);
        read_check("pad_restart");
        status_check("pad_status");
    endtask

    task automatic test_resync();
        apply_reset();
        send(8'h10, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
        send(8'h20, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
        idle(2);
        status_check("resync_status");
        read_check("resync_word");
        read_check("resync_only_one");
    endtask

    task automatic test_full_rw();
        exp_t e;
        apply_reset();
        send_words(1, 64);
        idle(2);
        status_check("full_before");
        for (int k = 0; k < 7; k++) send(8'($urandom), 1'b0, 1'b0);
        e = exp_q.pop_front();           // the read in the same cycle frees a slot
        send(8'd65, 1'b0, 1'b0);
        @(negedge clk);
        data_valid_i = 1'b0;
        rd_i         = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        checks++;
        if ({word_valid_o, word_sof_o, word_eof_o, word_o} !== {1'b1, e}) begin
            errors++;
            $display("FAIL full_rw_read: got valid=%b %h expected valid=1 %h", word_valid_o, word_o, e.data);
        end
        idle(1);
        status_check("full_rw_status");
        for (int i = 0; i < 64; i++) read_check("full_drain");
        read_check("full_drain_extra");
        status_check("full_after_drain");
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int w = 1; w <= 65; w++) begin
            send_words(w, 1);
            idle(2);
            checks++;
            if ({empty_o, afull_o} !== {1'b0, exp_q.size() >= 48}) begin
                errors++;
                $display("FAIL ovf_fill_%0d {empty,afull}: got %b expected %b", w,
                         {empty_o, afull_o}, {1'b0, exp_q.size() >= 48});
            end
        end
        status_check("ovf_status");
        for (int i = 0; i < 64; i++) read_check("ovf_drain");
        read_check("ovf_drain_extra");
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 8; i++) send(8'($urandom), i == 0, 1'b0);
        test_reset("reset_over_pending_write");
        idle(2);
        status_check("no_write_after_reset");
        for (int i = 0; i < 4; i++) send(8'($urandom), i == 0, 1'b0);
        test_reset("mid_frame");
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
        idle(2);
        read_check("mid_clean_word");
        read_check("mid_only_one");
        status_check("mid_status");
    endtask

    task automatic test_random();
        apply_reset();
        for (int round = 0; round < 6; round++) begin
            int n;
            int reads;
            n = $urandom_range(30, 60);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            end
            idle(2);
            status_check("rand_status");
            reads = exp_q.size();
            for (int r = 0; r <= reads; r++) read_check("rand_read");
        end
        status_check("rand_final");
    endtask

    initial begin
        model_clear();
        test_reset("power_on");
        test_packing();
        test_eof_pad();
        test_resync();
        test_full_rw();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
